pic_ack_sequencer: RTL and testbench

- Control-logic sequencer for the 8259A-style controller; sits between the IR input pins, the priority resolver and the CPU bus interface.
- Owns IRR and ISR and feeds them to the priority resolver. Consumes the resolver's one-hot winner and runs the two-pulse INTA acknowledge.
- Drives the vector byte and services EOI commands, including rotate-on-EOI tracking of the lowest-priority level.

---
 rtl/pic_ack_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_pic_ack_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pic_ack_sequencer.sv
// Interrupt acknowledge sequencer for an 8259A-style controller: IRR/ISR ownership,
// two-pulse INTA handshake, vector output and EOI/rotation. Optional feature macro: AUTO_EOI_EN.
module pic_ack_sequencer #(
  parameter int VECTOR_BASE_W = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               ir_in,
  input  logic                     level_triggered,
  input  logic [VECTOR_BASE_W-1:0] vector_base,
  input  logic [7:0]               resolved_interrupt,
  input  logic                     inta_pulse,
  input  logic                     eoi_valid,
  input  logic                     eoi_specific,
  input  logic [2:0]               eoi_level,
  input  logic                     rotate_on_eoi,
  output logic [7:0]               interrupt_request_register,
  output logic [7:0]               in_service_register,
  output logic [7:0]               highest_level_in_service,
  output logic [2:0]               lowest_priority,
  output logic                     int_out,
  output logic [7:0]               data_out,
  output logic                     data_out_en
);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_ACK1} state_t;

  state_t                   state_q, state_d;
  logic [7:0]               irr_q, irr_d;
  logic [7:0]               isr_q, isr_d;
  logic [7:0]               ir_prev_q;
  logic [2:0]               lowest_q, lowest_d;
  logic                     int_out_q, int_out_d;
  logic [7:0]               data_q, data_d;
  logic                     den_q, den_d;
  logic [2:0]               ack_level_q, ack_level_d;
  logic [VECTOR_BASE_W-1:0] vbase_q, vbase_d;
`ifdef AUTO_EOI_EN
  logic                     spurious_q, spurious_d;
`endif

  logic [7:0] hlis;
  logic       ack1_fire, ack2_fire, res_any;
  logic [2:0] res_idx;
  logic [7:0] set_mask, eoi_mask, auto_mask;
  logic       eoi_cleared;
  logic [2:0] eoi_lvl;

  // Index of the lowest set bit; 7 when nothing is set.
  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Highest-priority ISR bit, scanning upward from lowest+1 with wrap.
  function automatic logic [7:0] highest_isr(input logic [7:0] isr, input logic [2:0] lowest);
    logic [7:0] r;
    logic       found;
    logic [2:0] idx;
    r     = 8'h00;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = lowest + 3'(k);
      if (!found && isr[idx]) begin
        r[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    hlis      = highest_isr(isr_q, lowest_q);
    res_any   = |resolved_interrupt;
    res_idx   = onehot_idx(resolved_interrupt);
    ack1_fire = (state_q == S_PENDING) && inta_pulse;
    ack2_fire = (state_q == S_ACK1) && inta_pulse;

    // EOI always looks at the ISR as it stood before this cycle's acknowledge.
    eoi_mask    = 8'h00;
    eoi_cleared = 1'b0;
    eoi_lvl     = 3'd0;
    if (eoi_valid) begin
      if (eoi_specific) begin
        if (isr_q[eoi_level]) begin
          eoi_mask[eoi_level] = 1'b1;
          eoi_cleared         = 1'b1;
          eoi_lvl             = eoi_level;
        end
      end else if (|isr_q) begin
        eoi_mask    = hlis;
        eoi_cleared = 1'b1;
        eoi_lvl     = onehot_idx(hlis);
      end
    end

    set_mask = 8'h00;
    if (ack1_fire && res_any) set_mask[res_idx] = 1'b1;

    auto_mask = 8'h00;
`ifdef AUTO_EOI_EN
    if (ack2_fire && !spurious_q) auto_mask[ack_level_q] = 1'b1;
`endif

    isr_d = (isr_q & ~(eoi_mask | auto_mask)) | set_mask;

    lowest_d = lowest_q;
`ifdef AUTO_EOI_EN
    if (ack2_fire && !spurious_q && rotate_on_eoi) lowest_d = ack_level_q;
`endif
    if (eoi_cleared && rotate_on_eoi) lowest_d = eoi_lvl;

    // Edge mode holds a request only while the line stays high after its rising edge.
    if (level_triggered) begin
      irr_d = ir_in;
    end else begin
      irr_d = ((irr_q | (ir_in & ~ir_prev_q)) & ir_in) & ~set_mask;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    den_d       = 1'b0;
    ack_level_d = ack_level_q;
    vbase_d     = vbase_q;
`ifdef AUTO_EOI_EN
    spurious_d  = spurious_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (res_any) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (inta_pulse) begin
          state_d     = S_ACK1;
          ack_level_d = res_any ? res_idx : 3'd7;
          vbase_d     = vector_base;
`ifdef AUTO_EOI_EN
          spurious_d  = !res_any;
`endif
        end
      end
      S_ACK1: begin
        if (inta_pulse) begin
          state_d = S_IDLE;
          data_d  = 8'({vbase_q, ack_level_q});
          den_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    int_out_d = (state_d == S_PENDING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      irr_q     <= 8'h00;
      isr_q     <= 8'h00;
      ir_prev_q <= 8'h00;
      lowest_q  <= 3'd7;
      int_out_q <= 1'b0;
      data_q    <= 8'h00;
      den_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      ir_prev_q <= ir_in;
      lowest_q  <= lowest_d;
      int_out_q <= int_out_d;
      data_q    <= data_d;
      den_q     <= den_d;
    end
  end

  always_ff @(posedge clk) begin
    ack_level_q <= ack_level_d;
    vbase_q     <= vbase_d;
`ifdef AUTO_EOI_EN
    spurious_q  <= spurious_d;
`endif
  end

  assign interrupt_request_register = irr_q;
  assign in_service_register        = isr_q;
  assign highest_level_in_service   = hlis;
  assign lowest_priority            = lowest_q;
  assign int_out                    = int_out_q;
  assign data_out                   = data_q;
  assign data_out_en                = den_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Directed bench for pic_ack_sequencer: acknowledge handshake, spurious INTA, EOI,
// rotation, EOI/INTA collision, mid-sequence reset and the optional auto-EOI.
module tb_pic_ack_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir_in;
  logic       level_triggered;
  logic [4:0] vector_base;
  logic [7:0] resolved_interrupt;
  logic       inta_pulse;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       rotate_on_eoi;
  logic [7:0] irr, isr, hlis, data_out;
  logic [2:0] lowest;
  logic       int_out, data_out_en;

  int n_tests = 0;
  int n_fail  = 0;

  pic_ack_sequencer #(.VECTOR_BASE_W(5)) dut (
    .clk(clk), .reset(reset), .ir_in(ir_in), .level_triggered(level_triggered),
    .vector_base(vector_base), .resolved_interrupt(resolved_interrupt),
    .inta_pulse(inta_pulse), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level), .rotate_on_eoi(rotate_on_eoi),
    .interrupt_request_register(irr), .in_service_register(isr),
    .highest_level_in_service(hlis), .lowest_priority(lowest), .int_out(int_out),
    .data_out(data_out), .data_out_en(data_out_en)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks one full acknowledge of the given level (resolver drives 1<<lvl).
  task automatic do_ack(input int lvl);
    resolved_interrupt = 8'(1 << lvl);
    step();
    inta_pulse = 1'b1;
    step();
    inta_pulse = 1'b0;
    resolved_interrupt = 8'h00;
    inta_pulse = 1'b1;
    step();
    inta_pulse = 1'b0;
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl, input logic rot);
    eoi_valid = 1'b1; eoi_specific = spec; eoi_level = lvl; rotate_on_eoi = rot;
    step();
    eoi_valid = 1'b0; eoi_specific = 1'b0; rotate_on_eoi = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_tests++; if (irr !== 8'h00) begin n_fail++; $display("FAIL reset_irr got %h exp 00", irr); end
    n_tests++; if (isr !== 8'h00) begin n_fail++; $display("FAIL reset_isr got %h exp 00", isr); end
    n_tests++; if (lowest !== 3'd7) begin n_fail++; $display("FAIL reset_lowest got %0d exp 7", lowest); end
    n_tests++; if (int_out !== 1'b0 || data_out_en !== 1'b0) begin n_fail++; $display("FAIL reset_int_den got %b%b exp 00", int_out, data_out_en); end
    n_tests++; if (data_out !== 8'h00 || hlis !== 8'h00) begin n_fail++; $display("FAIL reset_data_hlis got %h/%h exp 00/00", data_out, hlis); end
  endtask

  task automatic test_edge_ack();
    level_triggered = 1'b0;
    ir_in = 8'h04;
    step();
    n_tests++; if (irr !== 8'h04) begin n_fail++; $display("FAIL edge_irr_set got %h exp 04", irr); end
    resolved_interrupt = 8'h04;
    step();
    n_tests++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL pending_int got %b exp 1", int_out); end
    resolved_interrupt = 8'h00;
    step();
    n_tests++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL pending_hold_int got %b exp 1", int_out); end
    resolved_interrupt = 8'h04; vector_base = 5'h08; inta_pulse = 1'b1;
    step();
    inta_pulse = 1'b0; resolved_interrupt = 8'h00;
    n_tests++; if (isr !== 8'h04) begin n_fail++; $display("FAIL inta1_isr got %h exp 04", isr); end
    n_tests++; if (irr !== 8'h00) begin n_fail++; $display("FAIL inta1_irr got %h exp 00", irr); end
    n_tests++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL inta1_int got %b exp 0", int_out); end
    n_tests++; if (hlis !== 8'h04) begin n_fail++; $display("FAIL inta1_hlis got %h exp 04", hlis); end
    vector_base = 5'h1F;
    inta_pulse = 1'b1;
    step();
    inta_pulse = 1'b0;
    n_tests++; if (data_out !== 8'h42 || data_out_en !== 1'b1) begin n_fail++; $display("FAIL inta2_vec got %h en %b exp 42 en 1", data_out, data_out_en); end
    step();
    n_tests++; if (data_out !== 8'h42 || data_out_en !== 1'b0) begin n_fail++; $display("FAIL vec_hold got %h en %b exp 42 en 0", data_out, data_out_en); end
    ir_in = 8'h00;
    step();
    n_tests++; if (irr !== 8'h00) begin n_fail++; $display("FAIL edge_no_reset_irr got %h exp 00", irr); end
    eoi(1'b0, 3'd0, 1'b0);
    n_tests++; if (isr !== 8'h00 || lowest !== 3'd7) begin n_fail++; $display("FAIL nseoi_clean got %h/%0d exp 00/7", isr, lowest); end
  endtask

  task automatic test_level_mode();
    level_triggered = 1'b1;
    ir_in = 8'h81;
    step();
    n_tests++; if (irr !== 8'h81) begin n_fail++; $display("FAIL level_irr got %h exp 81", irr); end
    ir_in = 8'h00;
    step();
    n_tests++; if (irr !== 8'h00) begin n_fail++; $display("FAIL level_irr_drop got %h exp 00", irr); end
    level_triggered = 1'b0;
  endtask

  task automatic test_spurious();
    vector_base = 5'h08;
    resolved_interrupt = 8'h10;
    step();
    resolved_interrupt = 8'h00; inta_pulse = 1'b1;
    step();
    inta_pulse = 1'b0;
    n_tests++; if (isr !== 8'h00) begin n_fail++; $display("FAIL spur_isr got %h exp 00", isr); end
    inta_pulse = 1'b1;
    step();
    inta_pulse = 1'b0;
    n_tests++; if (data_out !== 8'h47 || data_out_en !== 1'b1) begin n_fail++; $display("FAIL spur_vec got %h en %b exp 47 en 1", data_out, data_out_en); end
    inta_pulse = 1'b1;
    step();
    inta_pulse = 1'b0;
    n_tests++; if (int_out !== 1'b0 || data_out_en !== 1'b0) begin n_fail++; $display("FAIL idle_inta got int %b en %b exp 0 0", int_out, data_out_en); end
  endtask

  task automatic test_nonspecific_eoi();
    do_ack(1);
    do_ack(3);
    n_tests++; if (isr !== 8'h0A || hlis !== 8'h02) begin n_fail++; $display("FAIL isr0a got %h hlis %h exp 0a 02", isr, hlis); end
    eoi(1'b0, 3'd6, 1'b0);
    n_tests++; if (isr !== 8'h08 || hlis !== 8'h08) begin n_fail++; $display("FAIL nseoi got %h hlis %h exp 08 08", isr, hlis); end
    eoi(1'b1, 3'd3, 1'b0);
    n_tests++; if (isr !== 8'h00 || lowest !== 3'd7) begin n_fail++; $display("FAIL seoi3 got %h/%0d exp 00/7", isr, lowest); end
  endtask

  task automatic test_rotate();
    do_ack(5);
    n_tests++; if (isr !== 8'h20) begin n_fail++; $display("FAIL rot_pre got %h exp 20", isr); end
    eoi(1'b1, 3'd5, 1'b1);
    n_tests++; if (isr !== 8'h00 || lowest !== 3'd5) begin n_fail++; $display("FAIL rot_seoi got %h/%0d exp 00/5", isr, lowest); end
    do_ack(2);
    do_ack(7);
    n_tests++; if (isr !== 8'h84 || hlis !== 8'h80) begin n_fail++; $display("FAIL rot_order got %h hlis %h exp 84 80", isr, hlis); end
    eoi(1'b0, 3'd0, 1'b1);
    n_tests++; if (isr !== 8'h04 || lowest !== 3'd7 || hlis !== 8'h04) begin n_fail++; $display("FAIL rot_nseoi got %h/%0d/%h exp 04/7/04", isr, lowest, hlis); end
    eoi(1'b1, 3'd2, 1'b0);
    eoi(1'b1, 3'd4, 1'b1);
    n_tests++; if (isr !== 8'h00 || lowest !== 3'd7) begin n_fail++; $display("FAIL rot_noop got %h/%0d exp 00/7", isr, lowest); end
  endtask

  task automatic test_simultaneous();
    do_ack(0);
    resolved_interrupt = 8'h08;
    step();
    inta_pulse = 1'b1; eoi_valid = 1'b1; eoi_specific = 1'b0;
    step();
    inta_pulse = 1'b0; eoi_valid = 1'b0; resolved_interrupt = 8'h00;
    n_tests++; if (isr !== 8'h08) begin n_fail++; $display("FAIL sim_nseoi got %h exp 08", isr); end
    inta_pulse = 1'b1;
    step();
    inta_pulse = 1'b0;
    n_tests++; if (data_out !== 8'h43) begin n_fail++; $display("FAIL sim_vec got %h exp 43", data_out); end
    resolved_interrupt = 8'h08;
    step();
    inta_pulse = 1'b1; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
    step();
    inta_pulse = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0; resolved_interrupt = 8'h00;
    n_tests++; if (isr !== 8'h08) begin n_fail++; $display("FAIL sim_same_level got %h exp 08", isr); end
    inta_pulse = 1'b1;
    step();
    inta_pulse = 1'b0;
    eoi(1'b1, 3'd3, 1'b0);
  endtask

  task automatic test_reset_mid();
    vector_base = 5'h08;
    resolved_interrupt = 8'h02;
    step();
    inta_pulse = 1'b1;
    step();
    inta_pulse = 1'b0; resolved_interrupt = 8'h00;
    n_tests++; if (isr !== 8'h02) begin n_fail++; $display("FAIL mid_pre got %h exp 02", isr); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_tests++; if (isr !== 8'h00 || irr !== 8'h00 || int_out !== 1'b0 || data_out !== 8'h00 || data_out_en !== 1'b0 || lowest !== 3'd7)
      begin n_fail++; $display("FAIL mid_reset got isr %h irr %h int %b data %h en %b low %0d", isr, irr, int_out, data_out, data_out_en, lowest); end
    inta_pulse = 1'b1;
    step();
    inta_pulse = 1'b0;
    n_tests++; if (data_out_en !== 1'b0 || data_out !== 8'h00 || isr !== 8'h00) begin n_fail++; $display("FAIL mid_inta_ignored got en %b data %h isr %h exp 0 00 00", data_out_en, data_out, isr); end
  endtask

  task automatic test_auto_eoi();
    vector_base = 5'h08;
    rotate_on_eoi = 1'b1;
    do_ack(2);
    rotate_on_eoi = 1'b0;
    n_tests++; if (data_out !== 8'h42 || data_out_en !== 1'b1) begin n_fail++; $display("FAIL auto_vec got %h en %b exp 42 1", data_out, data_out_en); end
`ifdef AUTO_EOI_EN
    n_tests++; if (isr !== 8'h00 || lowest !== 3'd2) begin n_fail++; $display("FAIL auto_eoi got %h/%0d exp 00/2", isr, lowest); end
`else
    n_tests++; if (isr !== 8'h04 || lowest !== 3'd7) begin n_fail++; $display("FAIL no_auto_eoi got %h/%0d exp 04/7", isr, lowest); end
    eoi(1'b1, 3'd2, 1'b0);
`endif
  endtask

  initial begin
    reset = 1'b0; ir_in = 8'h00; level_triggered = 1'b0; vector_base = 5'h00;
    resolved_interrupt = 8'h00; inta_pulse = 1'b0; eoi_valid = 1'b0;
    eoi_specific = 1'b0; eoi_level = 3'd0; rotate_on_eoi = 1'b0;
    #1;
    test_reset();
    test_edge_ack();
    test_level_mode();
    test_spurious();
    test_nonspecific_eoi();
    test_rotate();
    test_simultaneous();
    test_reset_mid();
    test_auto_eoi();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
